fetch_unit: RTL
===============

# fetch_unit

Sequential instruction-fetch stage holding the architectural PC register. Issues word requests to instruction memory over a req/ack handshake, presents each fetched instruction and its PC to decode over valid/ready, and accepts taken-branch redirects from execute, discarding wrong-path fetches. Sits directly upstream of the combinational next-count logic: the registered PC is the value that logic consumes, and sequential PC advance is performed here.

## Interface
- N, 32, address and instruction width in bits
- RESET_PC, 0, PC loaded on reset
- INCR, 4, sequential PC increment in bytes
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imemReq  out  1  request valid; held high until acknowledged
- imemAddr  out  N  request address; stable while imemReq is high
- imemAck  in  1  request complete; meaningful only while imemReq is high
- imemData  in  N  instruction word; valid in the cycle imemAck is high
- branchTaken  in  1  redirect strobe from execute, one cycle per redirect
- branchTarget  in  N  redirect address, valid with branchTaken
- decValid  out  1  decInstr/decPc valid
- decReady  in  1  decode accepts this cycle
- decInstr  out  N  fetched instruction
- decPc  out  N  address of decInstr
- pcOut  out  N  current PC register
- misalignErr  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States: IDLE, REQ, HOLD, DRAIN. Registers: pc, redirPc, decInstr, decPc, misalignErr.
- Reset (any cycle, any state): state=IDLE, pc=RESET_PC, redirPc=0, imemReq=0, imemAddr=RESET_PC, decValid=0, decInstr=0, decPc=0, misalignErr=0. Any outstanding memory request is abandoned; memory is reset in the same cycle.
- imemReq=1 in REQ and DRAIN only. imemAddr=pc in IDLE/REQ/HOLD; in DRAIN it stays at the address of the in-flight request. decValid=1 in HOLD only.
- IDLE: go to REQ unconditionally. A branchTaken here loads pc=branchTarget.
- REQ, imemAck=1, branchTaken=0: decInstr=imemData, decPc=pc, pc=pc+INCR, go to HOLD.
- REQ, imemAck=1, branchTaken=1: discard data, pc=branchTarget, stay in REQ. The new request starts next cycle.
- REQ, imemAck=0, branchTaken=1: redirPc=branchTarget, go to DRAIN. The address is not changed mid-request.
- DRAIN: on imemAck, discard data, pc=redirPc, go to REQ. A further branchTaken while in DRAIN overwrites redirPc (the newest target wins). If it coincides with imemAck, pc=branchTarget.
- HOLD, branchTaken=1: drop the held instruction, pc=branchTarget, go to REQ. This takes priority over decReady. Decode must ignore any valid&ready transfer in a branchTaken cycle.
- HOLD, decReady=1, branchTaken=0: transfer occurs, go to REQ.
- HOLD, decReady=0: hold decInstr/decPc/decValid stable.
- pc+INCR wraps modulo 2^N (0xFFFFFFFC+4 -> 0x00000000 for N=32). No overflow flag.
- pcOut=pc in all states.

## Timing
- Outputs decode directly from state/data flops. There is no combinational path from any input to any output.
- After rst deasserts at edge 0: IDLE in cycle 0, imemReq high from cycle 1.
- imemAck in cycle k gives decValid high in cycle k+1.
- Zero-wait memory (ack in the first REQ cycle) gives peak throughput of one instruction per 2 cycles.
- A redirect in REQ without ack costs the remaining memory latency plus 1 cycle before the target request.
- A redirect in HOLD: the target request is issued the next cycle.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - Any accepted branchTarget with bits [1:0] != 0 sets misalignErr=1. It stays set until rst.
  - The target is used with bits [1:0] forced to 0.
- FETCH_ALIGN_CHECK_EN undefined:
  - misalignErr is tied 0.
  - branchTarget is used unmodified.

## Test plan
- Reset, zero-wait memory, decReady=1 -> requests at 0x0,0x4,0x8. decPc/decInstr match the memory contents at those addresses, one transfer every 2 cycles.
- decReady held 0 for 5 cycles in HOLD -> decValid, decInstr and decPc are stable, imemReq=0, pc=decPc+4. Releasing decReady issues the next request.
- 3-cycle memory latency, branchTaken to 0x100 in the first REQ cycle -> imemAddr stays at the old address until ack. Data is discarded, the next request is at 0x100, and decode never sees the old word.
- Two redirects in DRAIN (0x200, then 0x300) -> the next request after ack is 0x300.
- pc=0xFFFFFFFC with ack -> decPc=0xFFFFFFFC, the next request is at 0x00000000.
- With FETCH_ALIGN_CHECK_EN, branchTarget=0x102 -> request at 0x100 and misalignErr=1 until rst, then 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction-fetch stage.
//
// Holds the architectural PC. Issues one word request at a time to
// instruction memory (req/ack), presents the fetched word and its PC to
// decode (valid/ready), and takes taken-branch redirects from execute.
// Wrong-path fetches are discarded.
//
// Parameters:
//   N         address / instruction width
//   RESET_PC  PC loaded on reset
//   INCR      sequential PC increment in bytes
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imemReq, imemAddr           memory request (address held until ack)
//   imemAck, imemData           memory completion and returned word
//   branchTaken, branchTarget   redirect strobe and target from execute
//   decValid, decReady          decode handshake
//   decInstr, decPc             fetched instruction and its address
//   pcOut                       current PC register
//   misalignErr                 sticky misaligned-redirect flag
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, redirect targets have bits [1:0]
//                         forced to zero and a misaligned target sets the
//                         sticky misalignErr flag; otherwise targets are
//                         used unmodified and misalignErr is tied low.

module fetch_unit #(
    parameter int unsigned    N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter logic [N-1:0]   INCR     = N'(4)
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imemReq,
    output logic [N-1:0] imemAddr,
    input  logic         imemAck,
    input  logic [N-1:0] imemData,
    input  logic         branchTaken,
    input  logic [N-1:0] branchTarget,
    output logic         decValid,
    input  logic         decReady,
    output logic [N-1:0] decInstr,
    output logic [N-1:0] decPc,
    output logic [N-1:0] pcOut,
    output logic         misalignErr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] pc;
    logic [N-1:0] pc_nx;
    logic [N-1:0] redir_pc;
    logic [N-1:0] redir_nx;
    logic         load_dec;
    logic [N-1:0] tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt = {branchTarget[N-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            misalignErr <= 1'b0;
        end else if (branchTaken && (branchTarget[1:0] != 2'b00)) begin
            misalignErr <= 1'b1;
        end
    end
`else
    assign tgt         = branchTarget;
    assign misalignErr = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            redir_pc <= '0;
            decInstr <= '0;
            decPc    <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            redir_pc <= redir_nx;
            if (load_dec) begin
                decInstr <= imemData;
                decPc    <= pc;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = REQ;
            REQ: begin
                if (imemAck && !branchTaken) begin
                    state_nx = HOLD;
                end else if (!imemAck && branchTaken) begin
                    state_nx = DRAIN;
                end
            end
            HOLD: begin
                // A redirect wins over decReady; the held word is dropped.
                if (branchTaken || decReady) begin
                    state_nx = REQ;
                end
            end
            DRAIN: begin
                if (imemAck) begin
                    state_nx = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // PC / redirect / decode-capture update. The in-flight address is never
    // changed: a redirect during an unacknowledged request parks the target
    // in redir_pc and pc keeps addressing the outstanding request.
    always_comb begin
        pc_nx    = pc;
        redir_nx = redir_pc;
        load_dec = 1'b0;
        case (state)
            IDLE: begin
                if (branchTaken) begin
                    pc_nx = tgt;
                end
            end
            REQ: begin
                if (imemAck && !branchTaken) begin
                    load_dec = 1'b1;
                    pc_nx    = pc + INCR;
                end else if (branchTaken) begin
                    if (imemAck) begin
                        pc_nx = tgt;
                    end else begin
                        redir_nx = tgt;
                    end
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    pc_nx = tgt;
                end
            end
            DRAIN: begin
                if (branchTaken) begin
                    redir_nx = tgt;
                end
                if (imemAck) begin
                    pc_nx = branchTaken ? tgt : redir_pc;
                end
            end
            default: ;
        endcase
    end

    // Outputs depend only on flops
    always_comb begin
        imemReq  = (state == REQ) || (state == DRAIN);
        decValid = (state == HOLD);
        imemAddr = pc;
        pcOut    = pc;
    end

endmodule
